adder_response_checker: RTL and testbench

Synthesizable response checker for the W-bit ripple/behavioural full adder. It is the receiving end of the adder stimulus stream. It samples each applied vector (a, b, cin) together with the DUT outputs (s, cout) and compares them against an internal reference sum. It keeps pass/fail statistics, captures the first failing vector and reports a verdict once a programmed number of vectors has been consumed. It sits beside the adder in on-chip self-test and replaces waveform/monitor inspection in benches.

---
 rtl/adder_chk_pkg.sv | 22 ++
 rtl/adder_ref_model.sv | 13 +
 rtl/adder_response_checker.sv | 122 ++++++++++++
 tb/tb_adder_response_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and width helpers for the adder response checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } chk_state_t;

  function automatic int vec_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int def_num_vectors(input int w);
    return 1 << (2 * w + 1);
  endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Combinational reference adder: full-width {cout,s} for a + b + cin.
module adder_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_response_checker.sv
// Adder response checker: error stats, first-fail capture, verdict.
// Optional seen-map coverage when ADDER_CHK_COVERAGE_EN is defined.
module adder_response_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = def_num_vectors(WIDTH),
  parameter int ERR_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       cin,
  input  logic [WIDTH-1:0]           s,
  input  logic                       cout,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [ERR_W-1:0]           err_cnt,
  output logic [cnt_w(WIDTH)-1:0]    vec_cnt,
  output logic [vec_w(WIDTH)-1:0]    fail_vec,
  output logic [WIDTH:0]             fail_res,
  output logic                       fail_seen,
  output logic [cnt_w(WIDTH)-1:0]    cov_cnt
);

  localparam int VW = vec_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  chk_state_t state_q, state_d;

  logic [WIDTH:0] exp_sum;
  logic           accept;
  logic           mismatch;
  logic           last;
  logic           arm;
  logic           cov_ok;
  logic [VW-1:0]  idx;

  adder_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a  (a),
    .b  (b),
    .cin(cin),
    .sum(exp_sum)
  );

  assign idx      = {a, b, cin};
  assign accept   = (state_q == RUN) && in_valid;
  assign mismatch = ({cout, s} != exp_sum);
  assign last     = (vec_cnt == CW'(NUM_VECTORS - 1));
  assign arm      = start && (state_q != RUN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign pass     = done && (err_cnt == '0) && cov_ok;

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      err_cnt   <= '0;
      vec_cnt   <= '0;
      fail_vec  <= '0;
      fail_res  <= '0;
      fail_seen <= 1'b0;
    end else if (accept) begin
      vec_cnt <= vec_cnt + CW'(1);
      if (mismatch) begin
        if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
        // Keep only the first failure of the run.
        if (!fail_seen) begin
          fail_seen <= 1'b1;
          fail_vec  <= idx;
          fail_res  <= {cout, s};
        end
      end
    end
  end

`ifdef ADDER_CHK_COVERAGE_EN
  localparam int MAP_N   = 1 << VW;
  localparam int COV_TGT = (NUM_VECTORS < MAP_N) ? NUM_VECTORS : MAP_N;

  logic [MAP_N-1:0] seen;

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      seen    <= '0;
      cov_cnt <= '0;
    end else if (accept && !seen[idx]) begin
      seen[idx] <= 1'b1;
      cov_cnt   <= cov_cnt + CW'(1);
    end
  end

  assign cov_ok = (cov_cnt == CW'(COV_TGT));
`else
  assign cov_cnt = '0;
  assign cov_ok  = 1'b1;
`endif

endmodule

// File: tb/tb_adder_response_checker.sv
// Scoreboard bench for adder_response_checker (WIDTH=4, 512 vectors).
module tb_adder_response_checker;

`ifdef ADDER_CHK_COVERAGE_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready;
  logic [3:0] a, b, s;
  logic       cin, cout;
  logic       busy, done, pass, fail_seen;
  logic [15:0] err_cnt;
  logic [9:0]  vec_cnt, cov_cnt;
  logic [8:0]  fail_vec;
  logic [4:0]  fail_res;

  adder_response_checker dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .s        (s),
    .cout     (cout),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .vec_cnt  (vec_cnt),
    .fail_vec (fail_vec),
    .fail_res (fail_res),
    .fail_seen(fail_seen),
    .cov_cnt  (cov_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    rdy, busy, done, pass, fs;
    int    err, vec, fv, fr, cov;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string t, input string f,
                     input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h want %0h", t, f, act, want);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, "in_ready", int'(in_ready), int'(e.rdy));
      cmp(e.tag, "busy", int'(busy), int'(e.busy));
      cmp(e.tag, "done", int'(done), int'(e.done));
      cmp(e.tag, "pass", int'(pass), int'(e.pass));
      cmp(e.tag, "err_cnt", int'(err_cnt), e.err);
      cmp(e.tag, "vec_cnt", int'(vec_cnt), e.vec);
      cmp(e.tag, "fail_seen", int'(fail_seen), int'(e.fs));
      cmp(e.tag, "fail_vec", int'(fail_vec), e.fv);
      cmp(e.tag, "fail_res", int'(fail_res), e.fr);
      cmp(e.tag, "cov_cnt", int'(cov_cnt), e.cov);
    end
  end

  function automatic int cv(input int n);
    return COV ? n : 0;
  endfunction

  task automatic snap(input string t, input bit rdy, input bit bz,
                      input bit dn, input bit ps, input int err,
                      input int vec, input bit fs, input int fv,
                      input int fr, input int cov);
    exp_t x;
    x.tag = t; x.rdy = rdy; x.busy = bz; x.done = dn; x.pass = ps;
    x.err = err; x.vec = vec; x.fs = fs; x.fv = fv; x.fr = fr;
    x.cov = cov;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [8:0] v, input logic [4:0] r,
                     input logic vld);
    a = v[8:5]; b = v[4:1]; cin = v[0];
    s = r[3:0]; cout = r[4]; in_valid = vld;
  endtask

  function automatic logic [4:0] good(input logic [8:0] v);
    return {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic sweep(input bit inject, input bit mid);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] r;
      v = 9'(i);
      r = good(v);
      if (inject && v[8:5] == 4'h3 && v[4:1] == 4'h5) r[3:0] = 4'h0;
      put(v, r, 1'b1);
      start = mid && (i == 300);
      step();
      start = 1'b0;
      if (mid && i == 300)
        snap("start_in_run", 1, 1, 0, 0, 0, 301, 0, 0, 0, cv(301));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    put(9'h0, 5'h0, 1'b0);
    step(); step();
    snap("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    put(9'h1FF, 5'h00, 1'b1);
    step();
    in_valid = 1'b0;
    snap("idle_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    pulse_start();
    snap("start", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    sweep(1'b0, 1'b1);
    snap("sweep_done", 0, 0, 1, 1, 0, 512, 0, 0, 0, cv(512));

    put(9'h1FF, 5'h00, 1'b1);
    step();
    in_valid = 1'b0;
    snap("done_drop", 0, 0, 1, 1, 0, 512, 0, 0, 0, cv(512));

    pulse_start();
    sweep(1'b1, 1'b0);
    snap("inject", 0, 0, 1, 0, 2, 512, 1, 'h06A, 'h00, cv(512));

    pulse_start();
    put(9'h1FF, 5'b11111, 1'b1);
    step();
    snap("wrap_ok", 1, 1, 0, 0, 0, 1, 0, 0, 0, cv(1));
    put(9'h1FF, 5'b01111, 1'b1);
    step();
    snap("wrap_bad", 1, 1, 0, 0, 1, 2, 1, 'h1FF, 'h0F, cv(1));
    for (int j = 0; j < 98; j++) begin
      put(9'(j), good(9'(j)), 1'b1);
      step();
    end
    snap("vec100", 1, 1, 0, 0, 1, 100, 1, 'h1FF, 'h0F, cv(99));

    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    snap("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    pulse_start();
    snap("restart", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 512; k++) begin
      put(9'h024, 5'h03, 1'b1);
      step();
    end
    in_valid = 1'b0;
    snap("repeat", 0, 0, 1, !COV, 0, 512, 0, 0, 0, cv(1));

    step(); step();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
